day04_sequencer: RTL and testbench
==================================

Name: day04_sequencer

Overview:
- Control block sitting between a host byte stream (pins/UART) and the day04 solver core.
- Buffers incoming ASCII characters in a small FIFO and forwards them to the core under its in_ready handshake.
- After the final character, pulses start, waits for out_valid with a timeout, captures the 32-bit count, and serves it back one byte per read strobe, LSB first.

Parameters:
- FIFO_DEPTH, 4, entries in the host-to-core character FIFO (power of two, at least 2).
- TIMEOUT_W, 24, width of the WAIT-state cycle counter; timeout fires at all-ones.
- RESULT_BYTES, 4, number of count bytes served on readout (1 to 4).

Ports:
- clock  in  1  system clock, rising edge
- clear  in  1  synchronous active-high reset
- host_char  in  8  ASCII input character
- host_valid  in  1  host_char valid
- host_last  in  1  qualifies host_char as the final character of the input
- host_part2  in  1  part select, sampled on the first accepted character
- host_ready  out  1  sequencer can accept host_char
- core_char  out  8  character to core in_char
- core_valid  out  1  to core in_valid
- core_ready  in  1  from core in_ready
- core_part2  out  1  latched part select to core part2
- core_start  out  1  one-cycle start pulse to core
- core_out_valid  in  1  from core out_valid
- core_count  in  32  from core out_count
- res_byte  out  8  current result byte
- res_valid  out  1  res_byte valid
- res_last  out  1  res_byte is the final result byte
- res_read  in  1  consume res_byte
- busy  out  1  high in every state except IDLE and ERROR
- done  out  1  one-cycle pulse when the final result byte is read
- error  out  1  timeout occurred; sticky until clear

Behaviour:
- Reset (clear=1 at a clock edge) from any state, including mid-load or mid-readout:
  - FSM goes to IDLE; FIFO is flushed; timeout counter, result shift register and byte index are zeroed.
  - core_part2=0, all outputs low except host_ready=1.
  - Characters in flight are dropped.
- FIFO:
  - host_ready = !full in IDLE and LOAD, 0 in all other states.
  - Push on host_valid & host_ready.
  - core_valid = !empty; core_char = head entry, registered, so there is no combinational path from host to core.
  - Pop on core_valid & core_ready.
  - Push and pop in the same cycle are both allowed when the FIFO is neither empty nor full; occupancy is unchanged.
  - When full, there is no push, even if a pop occurs that cycle.
- States:
  - IDLE: on first push, latch host_part2 into core_part2. If host_last is set on that push, go to DRAIN; otherwise go to LOAD.
  - LOAD: on push with host_last set, go to DRAIN. host_valid while host_ready=0 is ignored.
  - DRAIN: host_ready=0. When the FIFO is empty (last character has been popped), go to START.
  - START: core_start=1 for exactly one cycle. Zero the timeout counter. Go to WAIT.
  - WAIT:
    - core_out_valid=1: load core_count into the result shift register, byte index=0, go to RESULT. This check takes priority over timeout in the same cycle.
    - Otherwise the counter increments. When it reaches 2^TIMEOUT_W-1, go to ERROR.
  - RESULT:
    - res_valid=1; res_byte = shift[7:0]; res_last = (byte index == RESULT_BYTES-1).
    - res_read while res_valid shifts the register right by 8 (zero fill) and increments the byte index.
    - The read with res_last set pulses done and goes to IDLE.
    - res_read outside RESULT is ignored.
  - ERROR: error=1, busy=0, host_ready=0, no core outputs. Leaves only via clear.
- core_out_valid outside WAIT is ignored.
- The FIFO occupancy counter is log2(FIFO_DEPTH)+1 bits; pointers wrap modulo FIFO_DEPTH.

Optional Feature:
- Macro: DAY04_SEQ_CHECKSUM_EN.
- Defined:
  - An 8-bit XOR of every character popped to the core accumulates from IDLE.
  - It is served as an extra result byte after the RESULT_BYTES count bytes, so res_last moves to that byte.
  - The checksum clears on clear and on entry to IDLE.
- Undefined: no checksum logic; readout is exactly RESULT_BYTES bytes.

Test Plan:
- Reset mid-LOAD after 2 characters, then clear=1 for 1 cycle -> next cycle: FSM in IDLE, host_ready=1, core_valid=0, busy=0; the flushed characters never reach the core.
- Stream "@.@\n" ending with host_last, host_part2=1, core_ready=1 throughout, core returns count 0x00000013 -> core sees 4 characters in order; core_part2=1; single core_start pulse one cycle after the FIFO drains; res_byte sequence 0x13,0x00,0x00,0x00; res_last on the 4th; done pulses once.
- core_ready held low with 6 characters offered, FIFO_DEPTH=4 -> host_ready drops after 4 pushes; releasing core_ready delivers all 6 in order with no loss or duplication.
- Single character with host_last in IDLE -> DRAIN directly; start asserted after one pop.
- core_out_valid never asserts, TIMEOUT_W=4 -> ERROR entered 15 cycles after START; error=1 held, host_ready=0, until clear.
- With DAY04_SEQ_CHECKSUM_EN, input 0x40,0x2E,0x0A -> 5th result byte 0x64 with res_last=1.

Source files
------------

// File: rtl/day04_sequencer_if.sv
// day04_sequencer_if: host, core and result-readout signals of the day04
// sequencer bundled as one port group. The slave modport is the sequencer;
// the master modport is whatever sits around it (host, core, reader).
//
// Handshake rules:
// - host: a character transfers on a rising clock edge where host_valid and
//   host_ready are both high. host_ready never depends on host_valid.
// - core: a character transfers on an edge where core_valid and core_ready
//   are both high. core_valid/core_char come straight from registers.
// - result: a byte is consumed on an edge where res_valid and res_read are
//   both high. res_read while res_valid is low has no effect.
// state mirrors the sequencer FSM state register for observation only.
interface day04_sequencer_if;
    logic [7:0]  host_char;
    logic        host_valid;
    logic        host_last;
    logic        host_part2;
    logic        host_ready;
    logic [7:0]  core_char;
    logic        core_valid;
    logic        core_ready;
    logic        core_part2;
    logic        core_start;
    logic        core_out_valid;
    logic [31:0] core_count;
    logic [7:0]  res_byte;
    logic        res_valid;
    logic        res_last;
    logic        res_read;
    logic        busy;
    logic        done;
    logic        error;
    logic [2:0]  state;

    modport master (
        output host_char, host_valid, host_last, host_part2,
        output core_ready, core_out_valid, core_count,
        output res_read,
        input  host_ready,
        input  core_char, core_valid, core_part2, core_start,
        input  res_byte, res_valid, res_last,
        input  busy, done, error, state
    );

    modport slave (
        input  host_char, host_valid, host_last, host_part2,
        input  core_ready, core_out_valid, core_count,
        input  res_read,
        output host_ready,
        output core_char, core_valid, core_part2, core_start,
        output res_byte, res_valid, res_last,
        output busy, done, error, state
    );
endinterface

// File: rtl/day04_sequencer.sv
// day04_sequencer: buffers host characters in a small FIFO, forwards them to
// the day04 solver core, starts the core after the last character, waits for
// its result with a timeout and serves the 32-bit count back LSB first.
// Optional build macro DAY04_SEQ_CHECKSUM_EN appends an 8-bit XOR of every
// character forwarded to the core as one extra result byte.
module day04_sequencer #(
    parameter int FIFO_DEPTH   = 4,
    parameter int TIMEOUT_W    = 24,
    parameter int RESULT_BYTES = 4
) (
    input  logic             clock,
    input  logic             clear,
    day04_sequencer_if.slave bus
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
`ifdef DAY04_SEQ_CHECKSUM_EN
    localparam int NUM_BYTES = RESULT_BYTES + 1;
    localparam logic [2:0] CSUM_IDX = 3'(RESULT_BYTES);
`else
    localparam int NUM_BYTES = RESULT_BYTES;
`endif
    localparam logic [2:0] LAST_IDX = 3'(NUM_BYTES - 1);
    // The counter value one step before all-ones: incrementing from here
    // reaches the timeout value on the same edge that enters ERROR.
    localparam logic [TIMEOUT_W-1:0] TIMER_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_DRAIN  = 3'd2,
        S_START  = 3'd3,
        S_WAIT   = 3'd4,
        S_RESULT = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [7:0]           mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [CW-1:0]        count;
    logic                 empty;
    logic                 full;
    logic                 push;
    logic                 pop;
    logic [7:0]           head;

    logic [TIMEOUT_W-1:0] timer;
    logic [31:0]          shift;
    logic [2:0]           idx;
    logic                 part2_q;
`ifdef DAY04_SEQ_CHECKSUM_EN
    logic [7:0]           csum;
`endif

    logic                 host_ready_c;
    logic                 core_start_c;
    logic                 busy_c;
    logic                 error_c;
    logic                 res_valid_c;
    logic                 res_last_c;
    logic [7:0]           res_byte_c;
    logic                 done_c;
    logic                 res_read_c;

    assign empty = (count == '0);
    assign full  = (count == FULL_COUNT);
    assign push  = bus.host_valid && host_ready_c;
    assign pop   = !empty && bus.core_ready;
    // Head is a register mux; gated to zero so an empty FIFO shows no stale data.
    assign head  = empty ? 8'h00 : mem[rd_ptr];
    assign res_read_c = (state_q == S_RESULT) && bus.res_read;

    // FSM state register.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (push) begin
                    state_d = bus.host_last ? S_DRAIN : S_LOAD;
                end
            end
            S_LOAD: begin
                if (push && bus.host_last) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (empty) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A result arriving on the timeout cycle still wins.
                if (bus.core_out_valid) begin
                    state_d = S_RESULT;
                end else if (timer == TIMER_LAST) begin
                    state_d = S_ERROR;
                end
            end
            S_RESULT: begin
                if (res_read_c && res_last_c) begin
                    state_d = S_IDLE;
                end
            end
            S_ERROR: begin
                state_d = S_ERROR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM-decoded outputs.
    always_comb begin
        host_ready_c = 1'b0;
        core_start_c = 1'b0;
        busy_c       = 1'b0;
        error_c      = 1'b0;
        res_valid_c  = 1'b0;
        res_last_c   = 1'b0;
        res_byte_c   = 8'h00;
        done_c       = 1'b0;
        case (state_q)
            S_IDLE: begin
                host_ready_c = !full;
            end
            S_LOAD: begin
                host_ready_c = !full;
                busy_c       = 1'b1;
            end
            S_DRAIN: begin
                busy_c = 1'b1;
            end
            S_START: begin
                busy_c       = 1'b1;
                core_start_c = 1'b1;
            end
            S_WAIT: begin
                busy_c = 1'b1;
            end
            S_RESULT: begin
                busy_c      = 1'b1;
                res_valid_c = 1'b1;
                res_last_c  = (idx == LAST_IDX);
                res_byte_c  = shift[7:0];
`ifdef DAY04_SEQ_CHECKSUM_EN
                if (idx == CSUM_IDX) begin
                    res_byte_c = csum;
                end
`endif
                done_c = bus.res_read && res_last_c;
            end
            S_ERROR: begin
                error_c = 1'b1;
            end
            default: begin
                busy_c = 1'b0;
            end
        endcase
    end

    // FIFO storage; contents need no reset because reads are gated by count.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= bus.host_char;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clock) begin
        if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Part select latched from the first accepted character of a job.
    always_ff @(posedge clock) begin
        if (clear) begin
            part2_q <= 1'b0;
        end else if ((state_q == S_IDLE) && push) begin
            part2_q <= bus.host_part2;
        end
    end

    // Timeout counter: zeroed in START, counts every WAIT cycle without a result.
    always_ff @(posedge clock) begin
        if (clear) begin
            timer <= '0;
        end else if (state_q == S_START) begin
            timer <= '0;
        end else if ((state_q == S_WAIT) && !bus.core_out_valid) begin
            timer <= timer + 1'b1;
        end
    end

    // Result shift register and byte index for LSB-first readout.
    always_ff @(posedge clock) begin
        if (clear) begin
            shift <= '0;
            idx   <= '0;
        end else if ((state_q == S_WAIT) && bus.core_out_valid) begin
            shift <= bus.core_count;
            idx   <= '0;
        end else if (res_read_c) begin
            shift <= {8'h00, shift[31:8]};
            idx   <= idx + 3'd1;
        end
    end

`ifdef DAY04_SEQ_CHECKSUM_EN
    // XOR of every character handed to the core since the last return to IDLE.
    always_ff @(posedge clock) begin
        if (clear) begin
            csum <= 8'h00;
        end else if ((state_d == S_IDLE) && (state_q != S_IDLE)) begin
            csum <= 8'h00;
        end else if (pop) begin
            csum <= csum ^ head;
        end
    end
`endif

    assign bus.host_ready = host_ready_c;
    assign bus.core_char  = head;
    assign bus.core_valid = !empty;
    assign bus.core_part2 = part2_q;
    assign bus.core_start = core_start_c;
    assign bus.res_byte   = res_byte_c;
    assign bus.res_valid  = res_valid_c;
    assign bus.res_last   = res_last_c;
    assign bus.busy       = busy_c;
    assign bus.done       = done_c;
    assign bus.error      = error_c;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_day04_sequencer.sv
// tb_day04_sequencer: randomized and directed stimulus for day04_sequencer,
// checked against a job-level model: the characters accepted from the host
// must reach the core in order, exactly once, before a single start pulse,
// and the readout must return the count LSB first (plus the XOR checksum
// byte when DAY04_SEQ_CHECKSUM_EN is defined).
module tb_day04_sequencer;

    localparam int FD = 4;
    localparam int TW = 4;
    localparam int RB = 4;
`ifdef DAY04_SEQ_CHECKSUM_EN
    localparam int NB = RB + 1;
`else
    localparam int NB = RB;
`endif

    logic clock;
    logic clear;

    day04_sequencer_if bus ();

    day04_sequencer #(
        .FIFO_DEPTH  (FD),
        .TIMEOUT_W   (TW),
        .RESULT_BYTES(RB)
    ) dut (
        .clock(clock),
        .clear(clear),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    logic [7:0] job_q[$];
    logic [7:0] csum_exp;
    int         start_cnt;
    int         done_cnt;

    // Clock and watchdog.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired got=running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Core-side scoreboard: every transfer to the core must match the oldest
    // accepted character.
    always @(negedge clock) begin
        if (!clear) begin
            if (bus.core_valid && bus.core_ready) begin
                if (exp_q.size() == 0) begin
                    check_val("core_extra_char", {24'h0, bus.core_char}, 32'h100);
                end else begin
                    check_val("core_char", {24'h0, bus.core_char}, {24'h0, exp_q.pop_front()});
                end
            end
            if (bus.core_start) start_cnt++;
            if (bus.done) done_cnt++;
        end
    end

    task automatic drive_idle();
        bus.host_char      = 8'h00;
        bus.host_valid     = 1'b0;
        bus.host_last      = 1'b0;
        bus.host_part2     = 1'b0;
        bus.core_ready     = 1'b0;
        bus.core_out_valid = 1'b0;
        bus.core_count     = 32'h0;
        bus.res_read       = 1'b0;
    endtask

    task automatic do_clear();
        drive_idle();
        clear = 1'b1;
        exp_q.delete();
        tick();
        clear = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check_val({tag, "_host_ready"}, bus.host_ready, 1);
        check_val({tag, "_core_valid"}, bus.core_valid, 0);
        check_val({tag, "_core_part2"}, bus.core_part2, 0);
        check_val({tag, "_core_start"}, bus.core_start, 0);
        check_val({tag, "_res_valid"}, bus.res_valid, 0);
        check_val({tag, "_busy"}, bus.busy, 0);
        check_val({tag, "_error"}, bus.error, 0);
        check_val({tag, "_done"}, bus.done, 0);
    endtask

    // Offer job_q to the host port; the first `hold` cycles keep the core
    // stalled with a character always offered.
    task automatic feed(input int n, input logic part2, input int hold, input bit rnd);
        int   idx   = 0;
        int   guard = 0;
        logic rdy;
        csum_exp  = 8'h00;
        start_cnt = 0;
        done_cnt  = 0;
        while (idx < n && guard < 500) begin
            if (guard < hold) begin
                bus.core_ready = 1'b0;
                bus.host_valid = 1'b1;
            end else begin
                bus.core_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                bus.host_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            bus.res_read   = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.host_char  = job_q[idx];
            bus.host_last  = (idx == n - 1);
            bus.host_part2 = (idx == 0) ? part2 : 1'($urandom_range(0, 1));
            rdy = bus.host_ready;
            tick();
            if (bus.host_valid && rdy) begin
                exp_q.push_back(job_q[idx]);
                csum_exp = csum_exp ^ job_q[idx];
                idx++;
            end
            guard++;
            if (hold > 0 && guard == hold) begin
                check_val("hold_accepted", idx, (n < FD) ? n : FD);
                check_val("hold_host_ready", bus.host_ready, 0);
            end
        end
        bus.host_valid = 1'b0;
        bus.host_last  = 1'b0;
        bus.res_read   = 1'b0;
        check_val("feed_all_accepted", idx, n);
    endtask

    task automatic wait_start(input bit rnd);
        int guard = 0;
        while (!bus.core_start && guard < 300) begin
            bus.core_ready     = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.core_out_valid = rnd ? ($urandom_range(0, 5) == 0) : 1'b0;
            tick();
            guard++;
        end
        bus.core_out_valid = 1'b0;
        check_val("start_seen", bus.core_start, 1);
        check_val("drained_before_start", exp_q.size(), 0);
    endtask

    task automatic finish_job(input logic part2, input logic [31:0] cnt, input bit rnd);
        int         d;
        int         gap;
        logic [7:0] exp_b;
        wait_start(rnd);
        check_val("core_part2", bus.core_part2, part2);
        d = rnd ? $urandom_range(0, 10) : 0;
        tick();
        repeat (d) tick();
        bus.core_out_valid = 1'b1;
        bus.core_count     = cnt;
        tick();
        bus.core_out_valid = 1'b0;
        bus.core_count     = $urandom;
        for (int i = 0; i < NB; i++) begin
            gap = rnd ? $urandom_range(0, 2) : 0;
            repeat (gap) tick();
            if (i < RB) exp_b = 8'((cnt >> (8 * i)) & 32'hFF);
            else        exp_b = csum_exp;
            check_val("res_valid", bus.res_valid, 1);
            check_val("res_byte", bus.res_byte, exp_b);
            check_val("res_last", bus.res_last, (i == NB - 1));
            bus.res_read = 1'b1;
            #1;
            check_val("done", bus.done, (i == NB - 1));
            tick();
            bus.res_read = 1'b0;
        end
        check_val("idle_after_busy", bus.busy, 0);
        check_val("idle_after_host_ready", bus.host_ready, 1);
        check_val("idle_after_res_valid", bus.res_valid, 0);
        check_val("start_pulses", start_cnt, 1);
        check_val("done_pulses", done_cnt, 1);
    endtask

    task automatic run_job(input logic part2, input logic [31:0] cnt, input int hold, input bit rnd);
        feed(job_q.size(), part2, hold, rnd);
        finish_job(part2, cnt, rnd);
    endtask

    // Main sequence.
    initial begin
        int         n;
        int         cyc;
        logic [7:0] c;

        drive_idle();
        clear = 1'b1;
        repeat (3) tick();
        do_clear();
        check_reset("rst");

        // Example grid row, part 2, count 0x13.
        job_q = '{8'h40, 8'h2E, 8'h40, 8'h0A};
        run_job(1'b1, 32'h0000_0013, 0, 1'b0);
        do_clear();
        check_reset("rst_after_job");

        // Single character with host_last goes straight to draining.
        job_q = '{8'h23};
        feed(1, 1'b0, 0, 1'b0);
        check_val("single_busy", bus.busy, 1);
        check_val("single_host_ready", bus.host_ready, 0);
        finish_job(1'b0, $urandom, 1'b0);

        // Backpressure: six characters against a stalled core.
        job_q.delete();
        for (int i = 0; i < 6; i++) job_q.push_back(8'($urandom_range(32, 126)));
        run_job(1'($urandom_range(0, 1)), $urandom, 10, 1'b0);

        // Checksum input pattern.
        job_q = '{8'h40, 8'h2E, 8'h0A};
        run_job(1'b0, $urandom, 0, 1'b0);

        // Reset in the middle of loading drops buffered characters.
        bus.core_ready = 1'b0;
        bus.host_valid = 1'b1;
        bus.host_last  = 1'b0;
        bus.host_char  = 8'hAA;
        tick();
        bus.host_char  = 8'h55;
        tick();
        bus.host_valid = 1'b0;
        check_val("midload_busy", bus.busy, 1);
        do_clear();
        check_reset("rst_midload");
        bus.core_ready = 1'b1;
        repeat (3) begin
            tick();
            check_val("flush_core_valid", bus.core_valid, 0);
        end
        job_q = '{8'h31, 8'h32};
        run_job(1'b1, $urandom, 0, 1'b1);

        // Timeout: the core never answers.
        job_q.delete();
        for (int i = 0; i < 3; i++) job_q.push_back(8'($urandom));
        feed(3, 1'b0, 0, 1'b1);
        wait_start(1'b1);
        cyc = 0;
        while (!bus.error && cyc < 60) begin
            tick();
            cyc++;
        end
        check_val("timeout_cycles", cyc, 1 + ((1 << TW) - 1));
        bus.host_valid = 1'b1;
        bus.host_char  = 8'h41;
        bus.res_read   = 1'b1;
        bus.core_out_valid = 1'b1;
        repeat (4) tick();
        check_val("err_error", bus.error, 1);
        check_val("err_host_ready", bus.host_ready, 0);
        check_val("err_busy", bus.busy, 0);
        check_val("err_core_valid", bus.core_valid, 0);
        check_val("err_core_start", bus.core_start, 0);
        check_val("err_res_valid", bus.res_valid, 0);
        do_clear();
        check_reset("rst_after_error");

        // Random jobs.
        for (int j = 0; j < 12; j++) begin
            n = $urandom_range(1, 7);
            job_q.delete();
            for (int i = 0; i < n; i++) begin
                c = 8'($urandom);
                job_q.push_back(c);
            end
            run_job(1'($urandom_range(0, 1)), $urandom, 0, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
